// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic op1_signed(input muldiv_op_e op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op2_signed(input muldiv_op_e op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of two independent values.
// Used before the iteration (absolute values) and after it (apply result signs).
module muldiv_signfix #(
  parameter int unsigned WA = 32,
  parameter int unsigned WB = 32
) (
  input  logic [WA-1:0] a,
  input  logic          neg_a,
  input  logic [WB-1:0] b,
  input  logic          neg_b,
  output logic [WA-1:0] y_a,
  output logic [WB-1:0] y_b
);

  assign y_a = neg_a ? ('0 - a) : a;
  assign y_b = neg_b ? ('0 - b) : b;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, fixed WIDTH-cycle iteration, signs applied at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_op1,
  input  logic [WIDTH-1:0] md_op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] md_out,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  muldiv_op_e         op_in, op_q;
  logic               accept;
  logic               sign1_in, sign2_in;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               s1_q, s2_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] prod_q, prod_nxt;
  logic [WIDTH:0]     rem_q, rem_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   shifted, trial;
  logic [2*WIDTH-1:0] post_a_in, post_a;
  logic [WIDTH-1:0]   post_b;
  logic [WIDTH-1:0]   result;

  assign op_in    = muldiv_op_e'(md_op);
  assign sign1_in = op1_signed(op_in) & md_op1[WIDTH-1];
  assign sign2_in = op2_signed(op_in) & md_op2[WIDTH-1];
  assign accept   = start & ~flush & ((state_q == IDLE) | (state_q == DONE));
  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);

  muldiv_signfix #(.WA(WIDTH), .WB(WIDTH)) u_pre (
    .a     (md_op1),
    .neg_a (sign1_in),
    .b     (md_op2),
    .neg_b (sign2_in),
    .y_a   (mag1),
    .y_b   (mag2)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // One iteration: multiply shifts the multiplier out of prod_q[0] while the
  // upper half accumulates; divide shifts the dividend out of the low half and
  // the quotient bits in behind it.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, m_q} : '0);
    shifted  = {rem_q, prod_q[WIDTH-1]};
    trial    = shifted - {2'b00, m_q};
    prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
    rem_nxt  = rem_q;
    if (is_div(op_q)) begin
      prod_nxt = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], ~trial[WIDTH+1]};
      rem_nxt  = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
    end
  end

  // Sign fix-up is fed from the final iteration's values so the result can be
  // registered on the same edge that enters DONE.
  assign post_a_in = is_div(op_q) ? {{WIDTH{1'b0}}, prod_nxt[WIDTH-1:0]} : prod_nxt;

  muldiv_signfix #(.WA(2*WIDTH), .WB(WIDTH)) u_post (
    .a     (post_a_in),
    .neg_a (s1_q ^ s2_q),
    .b     (rem_nxt[WIDTH-1:0]),
    .neg_b (s1_q),
    .y_a   (post_a),
    .y_b   (post_b)
  );

  // Result select; with a zero divisor the remainder iteration already leaves
  // |op1| in rem, so only the quotient needs forcing to all-ones.
  always_comb begin
    result = post_b;
    unique case (op_q)
      MUL:                result = post_a[WIDTH-1:0];
      MULH, MULHSU, MULHU: result = post_a[2*WIDTH-1:WIDTH];
      DIV, DIVU:          result = div_zero ? '1 : post_a[WIDTH-1:0];
      default:            result = post_b;
    endcase
  end

  // Operand latch on accept, iteration in CALC, result capture on the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MUL;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      m_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      md_out   <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      op_q     <= op_in;
      s1_q     <= sign1_in;
      s2_q     <= sign2_in;
      m_q      <= is_div(op_in) ? mag2 : mag1;
      prod_q   <= {{WIDTH{1'b0}}, (is_div(op_in) ? mag1 : mag2)};
      rem_q    <= '0;
      cnt_q    <= '0;
      div_zero <= is_div(op_in) && (md_op2 == '0);
    end else if ((state_q == CALC) && !flush) begin
      prod_q <= prod_nxt;
      rem_q  <= rem_nxt;
      if (cnt_q == LAST) md_out <= result;
      else               cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake corners,
// flush/reset, and randomized checks at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, flush;
  logic [2:0]  md_op;
  logic [31:0] op1, op2, md_out;
  logic        busy, done, div_zero;

  logic        s_start, s_flush;
  logic [2:0]  s_op;
  logic [7:0]  s_op1, s_op2, s_out;
  logic        s_busy, s_done, s_dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        dz;
  } vec_t;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .md_op(md_op),
    .md_op1(op1), .md_op2(op2), .busy(busy), .done(done),
    .md_out(md_out), .div_zero(div_zero)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .flush(s_flush), .md_op(s_op),
    .md_op1(s_op1), .md_op2(s_op2), .busy(s_busy), .done(s_done),
    .md_out(s_out), .div_zero(s_dz)
  );

  // RISC-V M-extension semantics for a w-bit datapath, plain integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a_in,
                                         input logic [31:0] b_in, input int w);
    logic [63:0] mask, a, b, ea, eb, p, r;
    longint sa, sb, q, minv;
    mask = (64'd1 << w) - 64'd1;
    a = {32'd0, a_in} & mask;
    b = {32'd0, b_in} & mask;
    sa = a[w-1] ? (longint'(a) - (longint'(1) << w)) : longint'(a);
    sb = b[w-1] ? (longint'(b) - (longint'(1) << w)) : longint'(b);
    minv = -(longint'(1) << (w - 1));
    r = '0;
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        ea = (op != 3'd3) ? 64'(sa) : a;
        eb = (op <= 3'd1) ? 64'(sb) : b;
        p = ea * eb;
        r = (op == 3'd0) ? (p & mask) : ((p >> w) & mask);
      end
      3'd4: begin
        if (b == 0) r = mask;
        else if (sa == minv && sb == -1) r = a;
        else begin q = sa / sb; r = 64'(q) & mask; end
      end
      3'd5: r = (b == 0) ? mask : (a / b);
      3'd6: begin
        if (b == 0) r = a;
        else if (sa == minv && sb == -1) r = '0;
        else begin q = sa % sb; r = 64'(q) & mask; end
      end
      default: r = (b == 0) ? a : (a % b);
    endcase
    return 32'(r);
  endfunction

  // Issue one op on the 32-bit unit; lat counts cycles from the accept cycle to done
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dz, output int lat);
    @(negedge clk);
    start = 1'b1; md_op = op; op1 = a; op2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; md_op = 3'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = md_out;
    dz  = div_zero;
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] res, output logic dz, output int lat);
    @(negedge clk);
    s_start = 1'b1; s_op = op; s_op1 = a; s_op2 = b;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0; s_op = 3'($urandom); s_op1 = 8'($urandom); s_op2 = 8'($urandom);
    lat = 1;
    while (!s_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = s_out;
    dz  = s_dz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; flush = 1'b0; md_op = '0; op1 = '0; op2 = '0;
    s_start = 1'b0; s_flush = 1'b0; s_op = '0; s_op1 = '0; s_op2 = '0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL reset_md_out got %h want 0", md_out); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    checks++; if (s_out !== 8'd0 || s_busy !== 1'b0) begin errors++; $display("FAIL reset_w8 got out=%h busy=%b want 0", s_out, s_busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[12];
    logic [31:0] res;
    logic dz;
    int lat;
    v[0]  = '{MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    v[1]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    v[2]  = '{MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 1'b0};
    v[3]  = '{MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    v[4]  = '{DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0};
    v[5]  = '{REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b0};
    v[6]  = '{DIVU,   32'd100,        32'd7,        32'd14,       1'b0};
    v[7]  = '{REMU,   32'd100,        32'd7,        32'd2,        1'b0};
    v[8]  = '{DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1'b1};
    v[9]  = '{REMU,   32'd5,          32'd0,        32'd5,        1'b1};
    v[10] = '{DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b0};
    v[11] = '{REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1'b0};
    foreach (v[i]) begin
      run32(v[i].op, v[i].a, v[i].b, res, dz, lat);
      checks++;
      if (res !== v[i].exp) begin
        errors++; $display("FAIL directed[%0d] md_out got %h want %h", i, res, v[i].exp);
      end
      checks++;
      if (dz !== v[i].dz) begin
        errors++; $display("FAIL directed[%0d] div_zero got %b want %b", i, dz, v[i].dz);
      end
      checks++;
      if (lat != 33) begin
        errors++; $display("FAIL directed[%0d] latency got %0d want 33", i, lat);
      end
    end
  endtask

  task automatic test_random32();
    logic [31:0] res, a, b, exp;
    logic [2:0] op;
    logic dz;
    int lat;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 300));
        default: ;
      endcase
      exp = ref_md(op, a, b, 32);
      run32(op, a, b, res, dz, lat);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL rand32 op=%0d a=%h b=%h md_out got %h want %h", op, a, b, res, exp);
      end
      checks++;
      if (dz !== (op[2] && b == 0) || lat != 33) begin
        errors++; $display("FAIL rand32 op=%0d div_zero/latency got %b/%0d want %b/33", op, dz, lat, op[2] && b == 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, exp1, exp2;
    int lat, lat2, hold_bad;
    a1 = $urandom; b1 = $urandom;
    a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
    exp1 = ref_md(MUL, a1, b1, 32);
    exp2 = ref_md(DIVU, a2, b2, 32);
    @(negedge clk);
    start = 1'b1; md_op = MUL; op1 = a1; op2 = b1;
    @(posedge clk);
    @(negedge clk);
    md_op = DIVU; op1 = a2; op2 = b2;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 33) begin errors++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
    checks++;
    if (md_out !== exp1) begin errors++; $display("FAIL b2b_first_result got %h want %h", md_out, exp1); end
    @(negedge clk);
    start = 1'b0;
    lat2 = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_done busy got %b want 1", busy); end
    hold_bad = 0;
    while (!done && lat2 < 100) begin
      if (md_out !== exp1) hold_bad++;
      @(negedge clk);
      lat2++;
    end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL b2b_md_out_hold got %0d changed cycles want 0", hold_bad); end
    checks++;
    if (lat2 != 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", lat2); end
    checks++;
    if (md_out !== exp2) begin errors++; $display("FAIL b2b_second_result got %h want %h", md_out, exp2); end
  endtask

  task automatic test_flush_reset();
    logic [31:0] res;
    logic dz;
    int lat, seen;
    run32(DIVU, 32'd1000, 32'd3, res, dz, lat);
    checks++;
    if (res !== 32'd333) begin errors++; $display("FAIL flush_setup got %h want %h", res, 32'd333); end
    @(negedge clk);
    start = 1'b1; md_op = MUL; op1 = 32'd99; op2 = 32'd77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_to_idle busy/done got %b/%b want 0/0", busy, done); end
    checks++;
    if (md_out !== 32'd333) begin errors++; $display("FAIL flush_md_out got %h want %h", md_out, 32'd333); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_done got %0d active cycles want 0", seen); end
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start busy got %b want 0", busy); end

    @(negedge clk);
    start = 1'b1; md_op = DIV; op1 = 32'd5; op2 = 32'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || div_zero !== 1'b1) begin errors++; $display("FAIL pre_reset busy/div_zero got %b/%b want 1/1", busy, div_zero); end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset busy/done got %b/%b want 0/0", busy, done); end
    checks++;
    if (md_out !== 32'd0 || div_zero !== 1'b0) begin errors++; $display("FAIL async_reset md_out/div_zero got %h/%b want 0/0", md_out, div_zero); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_no_done got %0d done cycles want 0", seen); end
  endtask

  task automatic test_w8();
    logic [7:0] cv[9];
    logic [7:0] res, a, b, exp;
    logic [2:0] op;
    logic dz;
    int lat, bad_lat, bad_dz;
    cv = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    bad_lat = 0;
    bad_dz = 0;
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 9; i++) begin
        for (int j = 0; j < 9; j++) begin
          op = 3'(o);
          exp = 8'(ref_md(op, {24'd0, cv[i]}, {24'd0, cv[j]}, 8));
          run8(op, cv[i], cv[j], res, dz, lat);
          checks++;
          if (res !== exp) begin
            errors++; $display("FAIL w8_corner op=%0d a=%h b=%h got %h want %h", op, cv[i], cv[j], res, exp);
          end
          if (lat != 9) bad_lat++;
          if (dz !== (op[2] && cv[j] == 0)) bad_dz++;
        end
      end
    end
    for (int k = 0; k < 300; k++) begin
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      exp = 8'(ref_md(op, {24'd0, a}, {24'd0, b}, 8));
      run8(op, a, b, res, dz, lat);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL w8_rand op=%0d a=%h b=%h got %h want %h", op, a, b, res, exp);
      end
      if (lat != 9) bad_lat++;
      if (dz !== (op[2] && b == 0)) bad_dz++;
    end
    checks++;
    if (bad_lat != 0) begin errors++; $display("FAIL w8_latency got %0d ops off 9 cycles want 0", bad_lat); end
    checks++;
    if (bad_dz != 0) begin errors++; $display("FAIL w8_div_zero got %0d wrong flags want 0", bad_dz); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random32();
    test_back_to_back();
    test_flush_reset();
    test_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
